// File: rtl/cache_controller_if.sv
// Bus bundle for cache_controller: CPU request port, main-memory port and
// the performance counters. The master side is the CPU/memory environment,
// the slave side is the controller itself.
interface cache_controller_if #(
   parameter int CNT_WIDTH = 16
);
   logic                 cpu_req;
   logic                 cpu_we;
   logic [31:0]          cpu_addr;
   logic [31:0]          cpu_wdata;
   logic [31:0]          cpu_rdata;
   logic                 cpu_ready;
   logic                 cpu_busy;
   logic [31:0]          mem_address;
   logic                 mem_read;
   logic                 mem_write;
   logic [31:0]          mem_wdata;
   logic [31:0]          mem_rdata;
   logic                 mem_ready;
   logic [CNT_WIDTH-1:0] hit_count;
   logic [CNT_WIDTH-1:0] miss_count;

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
      input  cpu_rdata, cpu_ready, cpu_busy, mem_address, mem_read, mem_write,
             mem_wdata, hit_count, miss_count
   );

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
      output cpu_rdata, cpu_ready, cpu_busy, mem_address, mem_read, mem_write,
             mem_wdata, hit_count, miss_count
   );
endinterface

// File: rtl/cache_controller.sv
// Direct-mapped, write-back, write-allocate cache controller with one
// 32-bit word per line, single-word memory transactions and saturating
// hit/miss counters.
module cache_controller #(
   parameter int INDEX_BITS    = 6,
   parameter int MEM_ADDR_BITS = 14,
   parameter int CNT_WIDTH     = 16
) (
   input  logic              clk,
   input  logic              rst,
   cache_controller_if.slave bus
);
   localparam int TAG_BITS = MEM_ADDR_BITS - 2 - INDEX_BITS;
   localparam int LINES    = 1 << INDEX_BITS;

   typedef enum logic [2:0] {
      IDLE, COMPARE, WB_REQ, WB_WAIT, ALLOC_REQ, ALLOC_WAIT, RESPOND
   } state_t;

   state_t                state, state_nxt;
   logic [INDEX_BITS-1:0] idx_q;
   logic [TAG_BITS-1:0]   tag_q;
   logic                  we_q;
   logic [31:0]           wdata_q;
   logic                  refill_q;
   logic [LINES-1:0]      valid_q;
   logic [LINES-1:0]      dirty_q;
   logic [31:0]           data_mem [LINES];
   logic [TAG_BITS-1:0]   tag_mem  [LINES];
   logic [CNT_WIDTH-1:0]  hit_q;
   logic [CNT_WIDTH-1:0]  miss_q;
   logic [31:0]           line_data;
   logic [TAG_BITS-1:0]   line_tag;
   logic                  hit;
   logic                  unused_addr;

   assign line_data   = data_mem[idx_q];
   assign line_tag    = tag_mem[idx_q];
   assign hit         = valid_q[idx_q] && (line_tag == tag_q);
   assign unused_addr = ^{bus.cpu_addr[31:MEM_ADDR_BITS], bus.cpu_addr[1:0]};

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:       if (bus.cpu_req) state_nxt = COMPARE;
         COMPARE: begin
            if (hit)                 state_nxt = RESPOND;
            else if (dirty_q[idx_q]) state_nxt = WB_REQ;
            else                     state_nxt = ALLOC_REQ;
         end
         WB_REQ:     state_nxt = WB_WAIT;
         WB_WAIT:    if (bus.mem_ready) state_nxt = ALLOC_REQ;
         ALLOC_REQ:  state_nxt = ALLOC_WAIT;
         ALLOC_WAIT: if (bus.mem_ready) state_nxt = COMPARE;
         RESPOND:    state_nxt = IDLE;
         default:    state_nxt = IDLE;
      endcase
   end

   // Request latch; refill_q marks the re-compare after a fill so it is not counted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q    <= '0;
         tag_q    <= '0;
         we_q     <= 1'b0;
         wdata_q  <= '0;
         refill_q <= 1'b0;
      end else if (state == IDLE && bus.cpu_req) begin
         idx_q    <= bus.cpu_addr[2 +: INDEX_BITS];
         tag_q    <= bus.cpu_addr[2+INDEX_BITS +: TAG_BITS];
         we_q     <= bus.cpu_we;
         wdata_q  <= bus.cpu_wdata;
         refill_q <= 1'b0;
      end else if (state == ALLOC_WAIT && bus.mem_ready) begin
         refill_q <= 1'b1;
      end
   end

   // Per-line valid and dirty flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         if (state == COMPARE && hit && we_q) dirty_q[idx_q] <= 1'b1;
         if (state == WB_WAIT && bus.mem_ready) dirty_q[idx_q] <= 1'b0;
         if (state == ALLOC_WAIT && bus.mem_ready) begin
            valid_q[idx_q] <= 1'b1;
            dirty_q[idx_q] <= 1'b0;
         end
      end
   end

   // Line data and tag storage (not reset; guarded by valid_q).
   always_ff @(posedge clk) begin
      if (state == ALLOC_WAIT && bus.mem_ready) begin
         data_mem[idx_q] <= bus.mem_rdata;
         tag_mem[idx_q]  <= tag_q;
      end else if (state == COMPARE && hit && we_q) begin
         data_mem[idx_q] <= wdata_q;
      end
   end

   // Saturating hit/miss counters, updated on the first compare of a request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit_q  <= '0;
         miss_q <= '0;
      end else if (state == COMPARE && !refill_q) begin
         if (hit) begin
            if (hit_q != '1) hit_q <= hit_q + 1'b1;
         end else begin
            if (miss_q != '1) miss_q <= miss_q + 1'b1;
         end
      end
   end

   // Memory address: victim line during write-back, latched request otherwise.
   always_comb begin
      bus.mem_address = '0;
      if (state == WB_REQ || state == WB_WAIT)
         bus.mem_address[MEM_ADDR_BITS-1:0] = {line_tag, idx_q, 2'b00};
      else
         bus.mem_address[MEM_ADDR_BITS-1:0] = {tag_q, idx_q, 2'b00};
   end

   // Data outputs are gated to their valid windows so they never show array X.
   always_comb begin
      bus.mem_wdata = '0;
      bus.cpu_rdata = '0;
      if (state == WB_REQ)  bus.mem_wdata = line_data;
      if (state == RESPOND) bus.cpu_rdata = line_data;
   end

   assign bus.cpu_ready  = (state == RESPOND);
   assign bus.cpu_busy   = (state != IDLE);
   assign bus.mem_write  = (state == WB_REQ);
   assign bus.mem_read   = (state == ALLOC_REQ);
   assign bus.hit_count  = hit_q;
   assign bus.miss_count = miss_q;
endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller: directed vector table from the
// test plan, hand sequences for delayed memory and mid-operation reset,
// counter saturation, then random traffic against a behavioural cache model.
module tb_cache_controller;
   localparam int CW = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   cache_controller_if #(.CNT_WIDTH(CW)) bus ();

   cache_controller #(
      .INDEX_BITS(6),
      .MEM_ADDR_BITS(14),
      .CNT_WIDTH(CW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Memory environment
   logic [31:0] mem_arr [4096];
   int          mem_delay = 1;
   int          hs_viol   = 0;
   logic [31:0] last_rd_addr, last_wr_addr, last_wr_data;

   // Reference model
   bit          ref_valid [64];
   bit          ref_dirty [64];
   logic [5:0]  ref_tag   [64];
   logic [31:0] ref_line  [64];
   logic [31:0] ref_mem   [4096];
   int          ref_hits, ref_miss;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int sat(input int v);
      return (v > (1 << CW) - 1) ? (1 << CW) - 1 : v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 64; i++) begin
         ref_valid[i] = 0;
         ref_dirty[i] = 0;
      end
      ref_hits = 0;
      ref_miss = 0;
   endtask

   // kind: 0 hit, 1 clean miss, 2 dirty miss
   task automatic model_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata, output int kind);
      int idx, tag, word;
      idx  = int'(addr[7:2]);
      tag  = int'(addr[13:8]);
      word = int'(addr[13:2]);
      if (ref_valid[idx] && ref_tag[idx] == 6'(tag)) begin
         kind = 0;
         ref_hits = sat(ref_hits + 1);
      end else begin
         kind = (ref_valid[idx] && ref_dirty[idx]) ? 2 : 1;
         ref_miss = sat(ref_miss + 1);
         if (kind == 2) ref_mem[{ref_tag[idx], 6'(idx)}] = ref_line[idx];
         ref_line[idx]  = ref_mem[word];
         ref_tag[idx]   = 6'(tag);
         ref_valid[idx] = 1;
         ref_dirty[idx] = 0;
      end
      if (we) begin
         ref_line[idx]  = wdata;
         ref_dirty[idx] = 1;
      end
      rdata = ref_line[idx];
   endtask

   // Memory responder, handshake monitor and spurious mem_ready while idle.
   initial begin : responder
      bit   pend, pend_rd, prev_rd, prev_wr;
      int   cnt, word;
      pend = 0; pend_rd = 0; prev_rd = 0; prev_wr = 0; cnt = 0; word = 0;
      bus.mem_ready = 1'b0;
      bus.mem_rdata = '0;
      forever begin
         @(negedge clk);
         bus.mem_ready = 1'b0;
         bus.mem_rdata = $urandom;
         if (rst) begin
            pend = 0; prev_rd = 0; prev_wr = 0;
         end else begin
            if (bus.mem_read && bus.mem_write) begin
               hs_viol++;
               $display("FAIL handshake_both: got rd=1 wr=1 expected not both");
            end
            if ((bus.mem_read && prev_rd) || (bus.mem_write && prev_wr)) begin
               hs_viol++;
               $display("FAIL handshake_width: got pulse 2 cycles expected 1");
            end
            prev_rd = bus.mem_read;
            prev_wr = bus.mem_write;
            if (pend) begin
               cnt--;
               if (cnt == 0) begin
                  bus.mem_ready = 1'b1;
                  if (pend_rd) bus.mem_rdata = mem_arr[word];
                  pend = 0;
               end
            end else if (bus.mem_read || bus.mem_write) begin
               pend    = 1;
               pend_rd = bus.mem_read;
               cnt     = mem_delay;
               word    = int'(bus.mem_address[13:2]);
               if (bus.mem_read) last_rd_addr = bus.mem_address;
               if (bus.mem_write) begin
                  last_wr_addr = bus.mem_address;
                  last_wr_data = bus.mem_wdata;
                  mem_arr[word] = bus.mem_wdata;
               end
            end else if (!bus.cpu_busy && ($urandom_range(0, 3) == 0)) begin
               bus.mem_ready = 1'b1;
            end
         end
      end
   end

   task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input bit hold, output logic [31:0] rdata, output int lat,
                         output int nrd, output int nwr, output int rdcyc, output int nready);
      lat = -1; nrd = 0; nwr = 0; rdcyc = 0; nready = 0; rdata = '0;
      @(negedge clk);
      bus.cpu_req   = 1'b1;
      bus.cpu_we    = we;
      bus.cpu_addr  = addr;
      bus.cpu_wdata = wdata;
      for (int k = 1; k <= 80; k++) begin
         @(negedge clk);
         if (k == 1 && !hold) begin
            bus.cpu_req   = 1'b0;
            bus.cpu_we    = 1'($urandom);
            bus.cpu_addr  = $urandom;
            bus.cpu_wdata = $urandom;
         end
         if (bus.mem_read) begin
            nrd++;
            if (rdcyc == 0) rdcyc = k;
         end
         if (bus.mem_write) nwr++;
         if (bus.cpu_ready) begin
            nready++;
            if (lat < 0) begin
               lat   = k;
               rdata = bus.cpu_rdata;
            end
            bus.cpu_req = 1'b0;
         end
         if (lat >= 0 && k >= lat + 2) break;
      end
      bus.cpu_req = 1'b0;
   endtask

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          exp_lat;
      logic [31:0] exp_rdata;
      int          exp_rd;
      int          exp_wr;
      int          exp_rdcyc;
      logic [31:0] exp_raddr;
   } vec_t;

   initial begin
      vec_t        vecs [5];
      logic [31:0] rdata, mrdata;
      int          lat, nrd, nwr, rdcyc, nready, kind, d, exp_lat, mism;
      logic [31:0] addr, wdata;
      logic        we;

      bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
      for (int i = 0; i < 4096; i++) begin
         mem_arr[i] = $urandom;
      end
      mem_arr[12'h010] = 32'hDEADBEEF;
      mem_arr[12'h050] = 32'hCAFEF00D;
      for (int i = 0; i < 4096; i++) ref_mem[i] = mem_arr[i];
      model_reset();

      vecs[0] = '{1'b0, 32'h0000_0040, 32'h0,         5, 32'hDEADBEEF, 1, 0, 2, 32'h40};
      vecs[1] = '{1'b0, 32'h0000_0040, 32'h0,         2, 32'hDEADBEEF, 0, 0, 0, 32'h0};
      vecs[2] = '{1'b1, 32'h0000_0040, 32'h12345678,  2, 32'h12345678, 0, 0, 0, 32'h0};
      vecs[3] = '{1'b0, 32'h0000_0040, 32'h0,         2, 32'h12345678, 0, 0, 0, 32'h0};
      vecs[4] = '{1'b0, 32'h0000_0140, 32'h0,         7, 32'hCAFEF00D, 1, 1, 4, 32'h140};

      // Reset state
      repeat (2) @(negedge clk);
      check("reset_outputs",
            {bus.cpu_ready, bus.cpu_busy, bus.mem_read, bus.mem_write, 28'h0}, 32'h0);
      check("reset_mem_address", bus.mem_address, 32'h0);
      check("reset_cpu_rdata", bus.cpu_rdata, 32'h0);
      check("reset_counters", {bus.hit_count, bus.miss_count}, 32'h0);
      rst = 1'b0;

      // Directed table
      for (int i = 0; i < 5; i++) begin
         model_op(vecs[i].we, vecs[i].addr, vecs[i].wdata, mrdata, kind);
         do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, 0, rdata, lat, nrd, nwr, rdcyc, nready);
         check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
         check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
         check($sformatf("vec%0d_mem_read", i), nrd, vecs[i].exp_rd);
         check($sformatf("vec%0d_mem_write", i), nwr, vecs[i].exp_wr);
         check($sformatf("vec%0d_ready_count", i), nready, 1);
         if (vecs[i].exp_rd != 0) begin
            check($sformatf("vec%0d_read_cycle", i), rdcyc, vecs[i].exp_rdcyc);
            check($sformatf("vec%0d_read_addr", i), last_rd_addr, vecs[i].exp_raddr);
         end
      end
      check("wb_addr", last_wr_addr, 32'h40);
      check("wb_data", last_wr_data, 32'h12345678);
      check("wb_mem_word", mem_arr[12'h010], 32'h12345678);
      check("table_hits", 32'(bus.hit_count), 32'd3);
      check("table_misses", 32'(bus.miss_count), 32'd2);

      // Delayed fill with cpu_req held high until cpu_ready
      mem_delay = 4;
      model_op(1'b0, 32'h44, 32'h0, mrdata, kind);
      do_req(1'b0, 32'h44, 32'h0, 1, rdata, lat, nrd, nwr, rdcyc, nready);
      check("hold_latency", lat, 8);
      check("hold_ready_count", nready, 1);
      check("hold_mem_read", nrd, 1);
      check("hold_mem_write", nwr, 0);
      check("hold_rdata", rdata, mrdata);

      // Reset in the middle of ALLOC_WAIT
      @(negedge clk);
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h80;
      @(negedge clk);
      bus.cpu_req = 1'b0;
      nrd = 0;
      for (int k = 0; k < 20 && nrd == 0; k++) begin
         @(negedge clk);
         if (bus.mem_read) nrd = 1;
      end
      check("rst_run_read_seen", nrd, 1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_run_ctrl",
            {bus.cpu_ready, bus.cpu_busy, bus.mem_read, bus.mem_write, 28'h0}, 32'h0);
      check("rst_run_addr", bus.mem_address, 32'h0);
      check("rst_run_counters", {bus.hit_count, bus.miss_count}, 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
      mem_delay = 1;
      model_op(1'b0, 32'h40, 32'h0, mrdata, kind);
      do_req(1'b0, 32'h40, 32'h0, 0, rdata, lat, nrd, nwr, rdcyc, nready);
      check("post_rst_latency", lat, 5);
      check("post_rst_rdata", rdata, mrdata);
      check("post_rst_miss", 32'(bus.miss_count), 32'd1);

      // Hit counter saturation
      for (int i = 0; i < (1 << CW) + 2; i++) begin
         model_op(1'b0, 32'h40, 32'h0, mrdata, kind);
         do_req(1'b0, 32'h40, 32'h0, 0, rdata, lat, nrd, nwr, rdcyc, nready);
      end
      check("hit_saturated", 32'(bus.hit_count), 32'h1F);
      check("miss_after_sat", 32'(bus.miss_count), 32'd1);

      // Random traffic against the model
      for (int i = 0; i < 200; i++) begin
         d         = $urandom_range(1, 3);
         mem_delay = d;
         we        = 1'($urandom_range(0, 1));
         wdata     = $urandom;
         addr      = ($urandom & 32'hFFFF_C003) | (32'($urandom_range(0, 3)) << 8)
                     | (32'($urandom_range(0, 3)) << 2);
         model_op(we, addr, wdata, mrdata, kind);
         exp_lat = (kind == 0) ? 2 : (kind == 1) ? 4 + d : 5 + 2 * d;
         do_req(we, addr, wdata, 0, rdata, lat, nrd, nwr, rdcyc, nready);
         check($sformatf("rnd%0d_latency", i), lat, exp_lat);
         check($sformatf("rnd%0d_rdata", i), rdata, mrdata);
         check($sformatf("rnd%0d_traffic", i), {nrd[15:0], nwr[15:0]},
               {16'(kind != 0), 16'(kind == 2)});
         check($sformatf("rnd%0d_counters", i), {bus.hit_count, bus.miss_count},
               32'({5'(ref_hits), 5'(ref_miss)}));
      end

      mism = 0;
      for (int i = 0; i < 4096; i++) if (mem_arr[i] !== ref_mem[i]) mism++;
      check("backing_memory", mism, 0);
      check("handshake_violations", hs_viol, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
